// File: rtl/mod4051_pp_accum_if.sv
// Valid/ready handshake bundle between the LUT partial-product stage, the
// mod-4051 accumulator and the downstream consumer of the modular product.
interface mod4051_pp_accum_if #(
    parameter int unsigned W = 12
) ();
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;

    // Producer of partial products and consumer of results.
    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

    // Accumulator side.
    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );
endinterface

// File: rtl/mod4051_pp_accum.sv
// Serial modulo-MOD accumulator: sums N_TERMS partial-product residues per operation and
// hands the result out over valid/ready. Optional sticky range check: MOD4051_ACC_RANGE_CHECK_EN.
module mod4051_pp_accum #(
    parameter int unsigned MOD     = 4051,
    parameter int unsigned W       = 12,
    parameter int unsigned N_TERMS = 16,
    parameter int unsigned CW      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    mod4051_pp_accum_if.slave    bus,
    output logic                 busy,
    output logic [CW-1:0]        beat_cnt,
    output logic                 err
);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    localparam logic [W-1:0]  ModW       = W'(MOD);
    localparam logic [W:0]    ModS       = (W + 1)'(MOD);
    localparam logic [CW-1:0] LastIdx    = CW'(N_TERMS - 1);
    localparam logic [CW-1:0] CntOne     = CW'(1);
    localparam bit            SingleTerm = (N_TERMS == 1);

    state_e          state_q, state_d;
    logic [W-1:0]    acc_q, acc_d;
    logic [W-1:0]    out_data_q, out_data_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            out_valid_q, out_valid_d;

    logic            in_ready;
    logic            beat;
    logic            in_oor;
    logic [W-1:0]    in_red;
    logic [W:0]      sum;
    logic [W-1:0]    sum_red;

    // Inputs lie in [0, 2**W) and 2*MOD > 2**W - 1, so one subtraction fully reduces them.
    assign in_oor = (bus.in_data >= ModW);
    assign in_red = in_oor ? (bus.in_data - ModW) : bus.in_data;

    // The reduced sum is < 2**W, so the W-bit subtraction wraps to the right value.
    assign sum     = {1'b0, acc_q} + {1'b0, in_red};
    assign sum_red = (sum >= ModS) ? (acc_q + in_red - ModW) : sum[W-1:0];

    assign in_ready = (state_q != StHold) && !flush;
    assign beat     = bus.in_valid && in_ready;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        out_data_d  = out_data_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;

        if (flush) begin
            state_d     = StIdle;
            acc_d       = '0;
            cnt_d       = '0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (beat) begin
                        acc_d = in_red;
                        cnt_d = CntOne;
                        if (SingleTerm) begin
                            state_d     = StHold;
                            out_valid_d = 1'b1;
                            out_data_d  = in_red;
                        end else begin
                            state_d = StAcc;
                        end
                    end
                end
                StAcc: begin
                    if (beat) begin
                        acc_d = sum_red;
                        cnt_d = cnt_q + CntOne;
                        if (cnt_q == LastIdx) begin
                            state_d     = StHold;
                            out_valid_d = 1'b1;
                            out_data_d  = sum_red;
                        end
                    end
                end
                StHold: begin
                    if (bus.out_ready) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                        cnt_d       = '0;
                    end
                end
                default: begin
                    state_d     = StIdle;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            out_data_q  <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef MOD4051_ACC_RANGE_CHECK_EN
    logic err_q, err_d;

    // Sticky: only rst clears it, flush deliberately does not.
    assign err_d = err_q | (beat & in_oor);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign busy          = (state_q != StIdle);
    assign beat_cnt      = cnt_q;

endmodule

// File: tb/tb_mod4051_pp_accum.sv
// Directed self-checking bench for mod4051_pp_accum with hand-computed residues.
// Expected err follows MOD4051_ACC_RANGE_CHECK_EN.
module tb_mod4051_pp_accum;

    localparam int unsigned W  = 12;
    localparam int unsigned CW = 8;
`ifdef MOD4051_ACC_RANGE_CHECK_EN
    localparam logic [31:0] RangeEn = 32'd1;
`else
    localparam logic [31:0] RangeEn = 32'd0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          busy;
    logic [CW-1:0] beat_cnt;
    logic          err;

    int n_checks = 0;
    int n_errors = 0;

    mod4051_pp_accum_if #(.W(W)) bus ();

    mod4051_pp_accum #(
        .MOD     (4051),
        .W       (W),
        .N_TERMS (16),
        .CW      (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .bus      (bus),
        .busy     (busy),
        .beat_cnt (beat_cnt),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat for exactly one edge; it must be accepted.
    task automatic send(input int unsigned v, input int unsigned exp_cnt);
        bus.in_valid = 1'b1;
        bus.in_data  = v[W-1:0];
        check_eq("in_ready_before_beat", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_eq("beat_cnt", 32'(beat_cnt), 32'(exp_cnt));
    endtask

    task automatic send_run(input int unsigned v, input int unsigned first_cnt,
                            input int unsigned last_cnt);
        for (int i = first_cnt; i <= last_cnt; i++) send(v, i);
    endtask

    // Called right after the 16th beat edge, with out_ready=1.
    task automatic expect_result(input string tag, input int unsigned exp);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 32'd1);
        check_eq({tag, "_out_data"}, 32'(bus.out_data), 32'(exp));
        check_eq({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
        check_eq({tag, "_hold_busy"}, 32'(busy), 32'd1);
        bus.out_ready = 1'b1;
        tick();
        check_eq({tag, "_idle_out_valid"}, 32'(bus.out_valid), 32'd0);
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idle_in_ready"}, 32'(bus.in_ready), 32'd1);
        check_eq({tag, "_idle_beat_cnt"}, 32'(beat_cnt), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        #12;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("rst_beat_cnt", 32'(beat_cnt), 32'd0);
        check_eq("rst_err", 32'(err), 32'd0);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        tick();

        // 16 x 4050 = 64800 = 15*4051 + 4035.
        send_run(4050, 1, 16);
        expect_result("max_in_range", 4035);
        check_eq("no_err_in_range", 32'(err), 32'd0);

        // 2000 + 2051 = 4051 -> 0.
        send(2000, 1);
        send(2051, 2);
        send_run(0, 3, 16);
        expect_result("wrap_a", 0);

        send(4050, 1);
        send(1, 2);
        send_run(0, 3, 16);
        expect_result("wrap_b", 0);

        // 4095 reduces to 44.
        send(4095, 1);
        check_eq("err_after_oor", 32'(err), RangeEn);
        send_run(0, 2, 16);
        expect_result("oor", 44);
        check_eq("err_sticky", 32'(err), RangeEn);

        // Backpressure: result held, no beats consumed.
        bus.out_ready = 1'b0;
        send_run(5, 1, 16);
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd7;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check_eq("bp_out_data", 32'(bus.out_data), 32'd80);
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("bp_beat_cnt", 32'(beat_cnt), 32'd16);
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        check_eq("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("bp_release_beat_cnt", 32'(beat_cnt), 32'd0);
        check_eq("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        bus.in_valid = 1'b0;
        check_eq("bp_next_first_beat", 32'(beat_cnt), 32'd1);
        send_run(7, 2, 16);
        expect_result("bp_next", 112);

        // Flush after 7 beats, with a beat offered during flush.
        send_run(100, 1, 7);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd100;
        #1;
        check_eq("flush_in_ready", 32'(bus.in_ready), 32'd0);
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check_eq("flush_beat_cnt", 32'(beat_cnt), 32'd0);
        check_eq("flush_busy", 32'(busy), 32'd0);
        check_eq("flush_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("flush_keeps_err", 32'(err), RangeEn);
        tick();
        check_eq("flush_no_output", 32'(bus.out_valid), 32'd0);
        send_run(1, 1, 16);
        expect_result("after_flush", 16);

        // Asynchronous reset while beat 9 is being presented.
        send_run(2, 1, 8);
        bus.in_valid = 1'b1;
        bus.in_data  = 12'd2;
        #3;
        rst = 1'b1;
        #1;
        check_eq("arst_beat_cnt", 32'(beat_cnt), 32'd0);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("arst_out_data", 32'(bus.out_data), 32'd0);
        check_eq("arst_err", 32'(err), 32'd0);
        #1;
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        tick();
        check_eq("arst_no_output", 32'(bus.out_valid), 32'd0);

        // Gapped input: a beat every other cycle.
        for (int i = 1; i <= 16; i++) begin
            send(3, i);
            if (i < 16) begin
                tick();
                check_eq("gap_cnt_hold", 32'(beat_cnt), 32'(i));
            end
        end
        expect_result("gapped", 48);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
